bandai_mapper_gen2: RTL and testbench

//  Parametrised successor of the 2003 cartridge mapper: address-keyed unlock, boot bitstream on SO,
//  N bank registers driving ROM/RAM upper address, GPIO with synchronised input sampling, software relock.

---
 rtl/bandai_mapper_gen2.sv | 145 ++++++++++++++
 tb/tb_bandai_mapper_gen2.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/bandai_mapper_gen2.sv
// Cartridge mapper: address-keyed unlock, boot bitstream on SO, bank registers
// driving ROM/RAM upper address, GPIO with synchronised sampling, software relock.
module bandai_mapper_gen2 #(
  parameter int                 N_BANKS = 4,
  parameter int                 RADDR_W = 7,
  parameter int                 GPIO_W  = 4,
  parameter int                 SEQ_LEN = 18,
  parameter logic [SEQ_LEN-1:0] SEQ     = 18'h0A280,
  parameter logic [7:0]         KEY0    = 8'h5A,
  parameter logic [7:0]         KEY1    = 8'hA5
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               CEn,
  input  logic               SSn,
  input  logic               WEn,
  input  logic               OEn,
  input  logic [7:0]         ADDR,
  input  logic [7:0]         DQ_I,
  output logic [7:0]         DQ_O,
  output logic               DQ_OE,
  output logic               SO,
  output logic               SO_OE,
  input  logic [GPIO_W-1:0]  IO_I,
  output logic [GPIO_W-1:0]  IO_O,
  output logic [GPIO_W-1:0]  IO_OE,
  output logic               ROMCEn,
  output logic               RAMCEn,
  output logic [RADDR_W-1:0] RADDR,
  output logic               LOCKED
);

  typedef enum logic [1:0] {LOCK_A = 2'b00, LOCK_B = 2'b01, STREAM = 2'b10, OPEN = 2'b11} state_t;

  localparam logic [SEQ_LEN-1:0] SH_FILL = SEQ_LEN'(1) << (SEQ_LEN - 1);

  state_t                        state_q;
  logic [SEQ_LEN-1:0]            shreg_q;
  logic [4:0]                    cnt_q;
  logic [N_BANKS-1:0][7:0]       bank_q;
  logic [GPIO_W-1:0]             ioc_q, ios_q;
  logic [GPIO_W-1:0]             io_s1_q, io_s2_q;
  logic [2:0]                    we_sync_q;

  logic       is_open, commit, mapped, rce, ram_sel, rom_sel;
  logic [3:0] seg;
  logic [7:0] rd, bsel;

  assign is_open = (state_q == OPEN);
  // we_sync_q[2] is the previous synced level, so this is a synced WEn rising edge
  assign commit  = we_sync_q[1] & ~we_sync_q[2] & is_open & ~(SSn & CEn);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q   <= LOCK_A;
      shreg_q   <= '1;
      cnt_q     <= '0;
      bank_q    <= '1;
      ioc_q     <= '0;
      ios_q     <= '0;
      io_s1_q   <= '0;
      io_s2_q   <= '0;
      we_sync_q <= '1;
    end else begin
      we_sync_q <= {we_sync_q[1:0], WEn};
      io_s1_q   <= IO_I;
      io_s2_q   <= io_s1_q;
      case (state_q)
        LOCK_A: if (ADDR == KEY0) state_q <= LOCK_B;
        LOCK_B: begin
          if (ADDR == KEY1) begin
            state_q <= STREAM;
            shreg_q <= SEQ;
            cnt_q   <= '0;
          end else if (ADDR != KEY0) begin
            state_q <= LOCK_A;
          end
        end
        STREAM: begin
          shreg_q <= (shreg_q >> 1) | SH_FILL;
          cnt_q   <= cnt_q + 5'd1;
          if (cnt_q == 5'(SEQ_LEN - 1)) state_q <= OPEN;
        end
        default: ;
      endcase
      if (commit) begin
        for (int i = 0; i < N_BANKS; i++)
          if (ADDR == 8'(32'hC0 + i)) bank_q[i] <= DQ_I;
        if (ADDR == 8'hCC) ioc_q <= DQ_I[GPIO_W-1:0];
        if (ADDR == 8'hCD) ios_q <= DQ_I[GPIO_W-1:0];
        if (ADDR == 8'hCE && DQ_I == 8'hA5) begin
          state_q <= LOCK_A;
          bank_q  <= '1;
          ioc_q   <= '0;
          ios_q   <= '0;
        end
      end
    end
  end

  always_comb begin
    rd     = '0;
    mapped = 1'b0;
    for (int i = 0; i < N_BANKS; i++)
      if (ADDR == 8'(32'hC0 + i)) begin
        rd     = bank_q[i];
        mapped = 1'b1;
      end
    case (ADDR)
      8'hCC: begin rd[GPIO_W-1:0] = ioc_q; mapped = 1'b1; end
      8'hCD: begin rd[GPIO_W-1:0] = (ioc_q & ios_q) | (~ioc_q & io_s2_q); mapped = 1'b1; end
      8'hCF: begin rd = {6'b0, state_q}; mapped = 1'b1; end
      default: ;
    endcase
  end

  assign DQ_OE = is_open & ~(SSn & CEn) & ~OEn & WEn & mapped;
  assign DQ_O  = DQ_OE ? rd : 8'h00;

  assign seg     = ADDR[7:4];
  assign rce     = is_open & SSn & ~CEn;
  assign ram_sel = rce & (seg == 4'd1);
  assign rom_sel = rce & (seg > 4'd1);
  assign RAMCEn  = ~ram_sel;
  assign ROMCEn  = ~rom_sel;

  always_comb begin
    bsel = bank_q[0];
    for (int i = 0; i < N_BANKS; i++)
      if (seg == 4'(i)) bsel = bank_q[i];
    RADDR = '0;
    if (ram_sel | rom_sel) begin
      // segments without their own bank borrow bank 0's low bits above the segment number
      if (32'(seg) >= N_BANKS) RADDR = {bank_q[0][RADDR_W-5:0], seg};
      else                     RADDR = bsel[RADDR_W-1:0];
    end
  end

  assign SO     = (state_q == STREAM) ? shreg_q[0] : 1'b1;
  assign SO_OE  = ~RST;
  assign LOCKED = ~is_open;
  assign IO_OE  = ioc_q;
  assign IO_O   = ios_q;

endmodule

// File: tb/tb_bandai_mapper_gen2.sv
// Directed bench for bandai_mapper_gen2: expected SO bits and read results are
// queued when stimulus is driven and popped when the DUT output is compared.
module tb_bandai_mapper_gen2;

  localparam logic [17:0] SEQ_P = 18'h0A280;
  localparam int          SEQ_LEN = 18;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       CEn = 1'b1, SSn = 1'b1, WEn = 1'b1, OEn = 1'b1;
  logic [7:0] ADDR = 8'h00, DQ_I = 8'h00;
  logic [3:0] IO_I = 4'h0;
  logic [7:0] DQ_O;
  logic       DQ_OE, SO, SO_OE, ROMCEn, RAMCEn, LOCKED;
  logic [3:0] IO_O, IO_OE;
  logic [6:0] RADDR;

  int checks = 0;
  int errors = 0;
  logic       so_sb[$];
  logic [8:0] rd_sb[$];

  bandai_mapper_gen2 dut (
    .CLK(CLK), .RST(RST), .CEn(CEn), .SSn(SSn), .WEn(WEn), .OEn(OEn),
    .ADDR(ADDR), .DQ_I(DQ_I), .DQ_O(DQ_O), .DQ_OE(DQ_OE), .SO(SO), .SO_OE(SO_OE),
    .IO_I(IO_I), .IO_O(IO_O), .IO_OE(IO_OE), .ROMCEn(ROMCEn), .RAMCEn(RAMCEn),
    .RADDR(RADDR), .LOCKED(LOCKED)
  );

  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic unlock(input int abort_at);
    logic [17:0] seqv;
    seqv = SEQ_P;
    CEn = 1'b1; SSn = 1'b1; OEn = 1'b1; WEn = 1'b1;
    ADDR = 8'h5A; tick();
    ADDR = 8'hA5; tick();
    ADDR = 8'h00;
    for (int i = 0; i < SEQ_LEN; i++) so_sb.push_back(seqv[i]);
    for (int i = 0; i < SEQ_LEN; i++) begin
      if (i == abort_at) begin
        RST = 1'b1; #1;
        chk("abort_so", 16'(SO), 16'h1);
        chk("abort_locked", 16'(LOCKED), 16'h1);
        chk("abort_so_oe", 16'(SO_OE), 16'h0);
        so_sb.delete();
        tick();
        RST = 1'b0; #1;
        return;
      end
      chk($sformatf("so_bit%0d", i), 16'(SO), 16'(so_sb.pop_front()));
      chk("stream_locked", 16'(LOCKED), 16'h1);
      tick();
    end
    chk("so_idle", 16'(SO), 16'h1);
    chk("open_locked", 16'(LOCKED), 16'h0);
  endtask

  task automatic write(input logic [7:0] a, input logic [7:0] d);
    ADDR = a; DQ_I = d; CEn = 1'b0; SSn = 1'b0; OEn = 1'b1;
    WEn = 1'b0;
    repeat (3) tick();
    WEn = 1'b1;
    repeat (4) tick();
    CEn = 1'b1; SSn = 1'b1; ADDR = 8'h00;
  endtask

  task automatic read(input logic [7:0] a, input logic oe, input logic [7:0] d);
    rd_sb.push_back({oe, d});
    ADDR = a; CEn = 1'b0; SSn = 1'b0; WEn = 1'b1; OEn = 1'b0;
    #1;
    chk($sformatf("rd_%h", a), 16'({DQ_OE, DQ_O}), 16'(rd_sb.pop_front()));
    OEn = 1'b1; CEn = 1'b1; SSn = 1'b1; ADDR = 8'h00;
    #1;
  endtask

  task automatic romram(input logic [7:0] a, input logic rom_n, input logic ram_n,
                        input logic [6:0] ra);
    ADDR = a; SSn = 1'b1; CEn = 1'b0; OEn = 1'b1;
    #1;
    chk($sformatf("romcen_%h", a), 16'(ROMCEn), 16'(rom_n));
    chk($sformatf("ramcen_%h", a), 16'(RAMCEn), 16'(ram_n));
    chk($sformatf("raddr_%h", a), 16'(RADDR), 16'(ra));
    CEn = 1'b1; ADDR = 8'h00;
    #1;
  endtask

  initial begin
    // reset state
    repeat (2) tick();
    chk("rst_so", 16'(SO), 16'h1);
    chk("rst_so_oe", 16'(SO_OE), 16'h0);
    chk("rst_locked", 16'(LOCKED), 16'h1);
    chk("rst_dq_oe", 16'(DQ_OE), 16'h0);
    chk("rst_romcen", 16'(ROMCEn), 16'h1);
    chk("rst_ramcen", 16'(RAMCEn), 16'h1);
    chk("rst_raddr", 16'(RADDR), 16'h0);
    RST = 1'b0; #1;
    chk("run_so_oe", 16'(SO_OE), 16'h1);

    // T2: broken key sequence keeps the mapper locked
    ADDR = 8'h5A; tick();
    ADDR = 8'h33; tick();
    ADDR = 8'hA5; tick();
    ADDR = 8'h00; tick();
    chk("badkey_so", 16'(SO), 16'h1);
    chk("badkey_locked", 16'(LOCKED), 16'h1);
    // repeated KEY0 keeps LOCK_B, then KEY1 starts the stream
    ADDR = 8'h5A; tick();
    unlock(99);

    // T3: bank registers drive the upper address
    write(8'hC0, 8'h2D);
    write(8'hC2, 8'h15);
    read(8'hC2, 1'b1, 8'h15);
    read(8'hC0, 1'b1, 8'h2D);
    romram(8'h40, 1'b0, 1'b1, 7'h54);
    romram(8'h20, 1'b0, 1'b1, 7'h15);
    romram(8'h10, 1'b1, 1'b0, 7'h7F);
    romram(8'h05, 1'b1, 1'b1, 7'h00);

    // T4: GPIO direction, drive and mixed readback
    IO_I = 4'hF;
    write(8'hCC, 8'h05);
    write(8'hCD, 8'h0A);
    chk("io_oe", 16'(IO_OE), 16'h5);
    chk("io_o", 16'(IO_O), 16'hA);
    read(8'hCD, 1'b1, 8'h0A);
    read(8'hCC, 1'b1, 8'h05);
    read(8'hCF, 1'b1, 8'h03);
    read(8'hC3, 1'b1, 8'hFF);
    read(8'hC4, 1'b0, 8'h00);
    read(8'hCE, 1'b0, 8'h00);

    // T5: relock needs the exact key byte
    write(8'hCE, 8'h00);
    chk("relock_bad_locked", 16'(LOCKED), 16'h0);
    read(8'hC2, 1'b1, 8'h15);
    write(8'hCE, 8'hA5);
    chk("relock_locked", 16'(LOCKED), 16'h1);
    chk("relock_io_oe", 16'(IO_OE), 16'h0);
    read(8'hCF, 1'b0, 8'h00);
    write(8'hC1, 8'h00);
    unlock(99);
    read(8'hC0, 1'b1, 8'hFF);
    read(8'hC1, 1'b1, 8'hFF);
    read(8'hC2, 1'b1, 8'hFF);

    // T6: reset during the stream aborts it; the next unlock replays everything
    write(8'hCE, 8'hA5);
    unlock(7);
    chk("post_abort_locked", 16'(LOCKED), 16'h1);
    chk("post_abort_so", 16'(SO), 16'h1);
    unlock(99);
    read(8'hCF, 1'b1, 8'h03);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
